// File: rtl/irrigation_valve_ctrl.sv
// Irrigation valve sequencer: hysteresis start/stop, minimum on-time,
// watering timeout with latched alarm, and post-watering soak hold-off.
module irrigation_valve_ctrl #(
    parameter int W        = 4,
    parameter int MIN_ON   = 4,
    parameter int MAX_ON   = 20,
    parameter int SOAK_CYC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_valid,
    input  logic [W-1:0] moisture,
    input  logic [W-1:0] tank_level,
    input  logic [W-1:0] low_thr,
    input  logic [W-1:0] high_thr,
    input  logic [W-1:0] tank_min,
    input  logic         fault_clr,
    output logic         valve,
    output logic         alarm,
    output logic         tank_low,
    output logic         cfg_err,
    output logic [1:0]   state,
    output logic [7:0]   cycles_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATER = 2'd1,
        SOAK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [7:0] MIN_ON_C = 8'(MIN_ON);
    localparam logic [7:0] MAX_ON_C = 8'(MAX_ON);
    localparam logic [7:0] SOAK_C   = 8'(SOAK_CYC);

    state_t     state_q, state_d;
    logic [7:0] on_cnt_q, on_cnt_d;
    logic [7:0] soak_cnt_q, soak_cnt_d;
    logic [7:0] cycles_q, cycles_d;
    logic       valve_q, alarm_q, tank_low_q, cfg_err_q;

    logic tank_ok, cfg_bad, start, dry_stop, wet_stop;

    assign tank_ok  = tank_level > tank_min;
    assign cfg_bad  = low_thr >= high_thr;
    assign start    = sample_valid && (moisture < low_thr)
                      && tank_ok && !cfg_bad;
    assign dry_stop = sample_valid && !tank_ok;
    // A wet sample before the minimum on-time is simply dropped.
    assign wet_stop = sample_valid && (moisture >= high_thr)
                      && (on_cnt_q >= MIN_ON_C);

    always_comb begin
        state_d    = state_q;
        on_cnt_d   = on_cnt_q;
        soak_cnt_d = soak_cnt_q;
        cycles_d   = cycles_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WATER;
                    on_cnt_d = 8'd1;
                end
            end
            WATER: begin
                if (dry_stop || wet_stop) begin
                    state_d    = SOAK;
                    soak_cnt_d = 8'd1;
                    if (cycles_q != 8'hFF) begin
                        cycles_d = cycles_q + 8'd1;
                    end
                end else if (on_cnt_q == MAX_ON_C) begin
                    state_d = FAULT;
                end else begin
                    on_cnt_d = on_cnt_q + 8'd1;
                end
            end
            SOAK: begin
                if (soak_cnt_q == SOAK_C) begin
                    state_d = IDLE;
                end else begin
                    soak_cnt_d = soak_cnt_q + 8'd1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            on_cnt_q   <= 8'd0;
            soak_cnt_q <= 8'd0;
            cycles_q   <= 8'd0;
            valve_q    <= 1'b0;
            alarm_q    <= 1'b0;
            tank_low_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            on_cnt_q   <= on_cnt_d;
            soak_cnt_q <= soak_cnt_d;
            cycles_q   <= cycles_d;
            valve_q    <= (state_d == WATER);
            alarm_q    <= (state_d == FAULT);
            cfg_err_q  <= cfg_bad;
            if (sample_valid) begin
                tank_low_q <= !tank_ok;
            end
        end
    end

    assign valve       = valve_q;
    assign alarm       = alarm_q;
    assign tank_low    = tank_low_q;
    assign cfg_err     = cfg_err_q;
    assign state       = state_q;
    assign cycles_done = cycles_q;

endmodule

// File: tb/tb_irrigation_valve_ctrl.sv
// Bench for irrigation_valve_ctrl: directed vector table, hand sequences
// for timeout / async reset / saturation, and randomized model compare.
module tb_irrigation_valve_ctrl;

    localparam int MIN_ON   = 4;
    localparam int MAX_ON   = 20;
    localparam int SOAK_CYC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sample_valid = 1'b0;
    logic [3:0] moisture = '0, tank_level = '0;
    logic [3:0] low_thr = '0, high_thr = '0, tank_min = '0;
    logic       fault_clr = 1'b0;
    logic       valve, alarm, tank_low, cfg_err;
    logic [1:0] state;
    logic [7:0] cycles_done;

    int n_chk  = 0;
    int n_fail = 0;

    irrigation_valve_ctrl #(
        .W(4), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .SOAK_CYC(SOAK_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .moisture(moisture), .tank_level(tank_level),
        .low_thr(low_thr), .high_thr(high_thr), .tank_min(tank_min),
        .fault_clr(fault_clr), .valve(valve), .alarm(alarm),
        .tank_low(tank_low), .cfg_err(cfg_err), .state(state),
        .cycles_done(cycles_done)
    );

    always #5 clk = ~clk;

    // Reference model: mode uses the published state codes,
    // soak is tracked as edges remaining rather than edges elapsed.
    int m_mode, m_open, m_soak_left, m_runs;
    bit m_tlow, m_cfg;

    task automatic model_reset();
        m_mode = 0; m_open = 0; m_soak_left = 0;
        m_runs = 0; m_tlow = 0; m_cfg = 0;
    endtask

    task automatic model_step();
        int  m, t, l, h, tm;
        bit  ok;
        m = moisture; t = tank_level; l = low_thr;
        h = high_thr; tm = tank_min;
        ok = t > tm;
        case (m_mode)
            0: if (sample_valid && m < l && ok && l < h) begin
                m_mode = 1; m_open = 1;
            end
            1: if (sample_valid && (!ok || (m >= h && m_open >= MIN_ON))) begin
                m_mode = 2; m_soak_left = SOAK_CYC;
                if (m_runs < 255) m_runs++;
            end else if (m_open == MAX_ON) begin
                m_mode = 3;
            end else begin
                m_open++;
            end
            2: begin
                m_soak_left--;
                if (m_soak_left == 0) m_mode = 0;
            end
            default: if (fault_clr) m_mode = 0;
        endcase
        if (sample_valid) m_tlow = !ok;
        m_cfg = l >= h;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(bit sv, int m, int t, int l, int h, int tm, bit fc);
        @(negedge clk);
        sample_valid = sv;
        moisture = 4'(m); tank_level = 4'(t);
        low_thr = 4'(l); high_thr = 4'(h); tank_min = 4'(tm);
        fault_clr = fc;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 5, 10, 2, 0);
        #2 rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [13:0] outs();
        return {state, valve, alarm, tank_low, cfg_err, cycles_done};
    endfunction

    typedef struct {
        bit sv; int m, t, l, h, tm; bit fc;
        logic [13:0] exp;
    } vec_t;

    function automatic vec_t mk(bit sv, int m, int t, int l, int h, int tm,
                                bit fc, int st, bit v, bit a, bit tl,
                                bit ce, int cd);
        vec_t r;
        r.sv = sv; r.m = m; r.t = t; r.l = l; r.h = h; r.tm = tm;
        r.fc = fc;
        r.exp = {2'(st), v, a, tl, ce, 8'(cd)};
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        int   cnt, lv, hv, tv, m, t;
        bit   dry, sv;

        tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 8, 5, 10, 2, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 8, 5, 10, 2, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 8, 5, 10, 2, 0, 2, 0, 0, 0, 0, 1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 8, 5, 10, 2, 0,  1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0,  1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 2, 5, 10, 2, 0,  2, 0, 0, 1, 0, 2));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0, 2, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 5, 10, 2, 0,  0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(1, 1, 2, 5, 10, 2, 0,  0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 10, 10, 2, 0, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, 0, 15, 10, 10, 2, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 10, 11, 2, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 15, 10, 11, 2, 0, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 10, 9, 2, 0,  1, 1, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 1, 10, 9, 2, 0,  2, 0, 0, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 10, 9, 2, 1,  2, 0, 0, 1, 1, 3));

        do_reset();
        chk("reset_outputs", 32'(outs()), 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].sv, tbl[i].m, tbl[i].t, tbl[i].l,
                  tbl[i].h, tbl[i].tm, tbl[i].fc);
            tick();
            chk($sformatf("vector_%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Timeout: valve must stay open exactly MAX_ON cycles.
        do_reset();
        drive(1, 3, 8, 5, 10, 2, 0);
        tick();
        cnt = valve ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 5, 10, 2, 0);
            tick();
            if (!valve) break;
            cnt++;
        end
        chk("timeout_valve_cycles", 32'(cnt), 32'(MAX_ON));
        chk("timeout_state", 32'(state), 32'd3);
        chk("timeout_alarm", 32'(alarm), 32'd1);
        drive(1, 3, 1, 5, 10, 2, 0);
        tick();
        chk("fault_tank_low", 32'(tank_low), 32'd1);
        chk("fault_holds", 32'(state), 32'd3);
        drive(1, 3, 8, 5, 10, 2, 0);
        tick();
        chk("fault_ignores_start", 32'(state), 32'd3);
        drive(0, 0, 0, 5, 10, 2, 1);
        tick();
        chk("fault_clr_state", 32'(state), 32'd0);
        chk("fault_clr_alarm", 32'(alarm), 32'd0);

        // Async reset in the middle of a run.
        do_reset();
        drive(1, 3, 8, 5, 10, 2, 0);
        tick();
        drive(1, 3, 2, 5, 10, 2, 0);
        tick();
        for (int i = 0; i < SOAK_CYC; i++) begin
            drive(0, 0, 0, 5, 10, 2, 0);
            tick();
        end
        drive(1, 3, 8, 5, 10, 2, 0);
        tick();
        drive(0, 0, 0, 5, 10, 2, 0);
        tick();
        chk("pre_reset_water", 32'({valve, cycles_done}), 32'h101);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valve", 32'(valve), 32'd0);
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_cycles", 32'(cycles_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of completed-run counter.
        for (int r = 0; r < 257; r++) begin
            drive(1, 3, 8, 5, 10, 2, 0);
            tick();
            drive(1, 3, 2, 5, 10, 2, 0);
            tick();
            for (int i = 0; i < SOAK_CYC; i++) begin
                drive(0, 0, 0, 5, 10, 2, 0);
                tick();
            end
            chk($sformatf("runs_after_%0d", r + 1), 32'(cycles_done),
                32'((r + 1 > 255) ? 255 : r + 1));
        end

        // Randomized epochs against the reference model.
        do_reset();
        for (int e = 0; e < 40; e++) begin
            lv  = $urandom_range(3, 12);
            hv  = (e % 4 == 3) ? int'($urandom_range(0, 15))
                               : lv + int'($urandom_range(0, 3));
            tv  = $urandom_range(0, 6);
            dry = $urandom_range(0, 2) != 0;
            for (int c = 0; c < 100; c++) begin
                sv = $urandom_range(0, 1) == 1;
                if (dry && $urandom_range(0, 15) != 0) begin
                    m = $urandom_range(0, lv - 1);
                    t = $urandom_range(tv + 1, 15);
                end else begin
                    m = $urandom_range(0, 15);
                    t = $urandom_range(0, 15);
                end
                drive(sv, m, t, lv, hv, tv, $urandom_range(0, 15) == 0);
                tick();
                chk("random_vs_model", 32'(outs()),
                    32'({2'(m_mode), m_mode == 1, m_mode == 3,
                         m_tlow, m_cfg, 8'(m_runs)}));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irrigation_valve_ctrl.md
Name: irrigation_valve_ctrl

Overview:
- Sequential valve controller for the irrigation system.
- Consumes 4-bit moisture and tank-level samples, and decides when to open and close the irrigation valve by comparing them against configurable thresholds.
- Enforces hysteresis, a minimum on-time, a watering timeout and a post-watering soak interval.
- Raises a latched alarm on timeout; sits between the sensor sampling logic and the valve driver/status display.

Parameters:
- W, 4, width of moisture, tank level and threshold values.
- MIN_ON, 4, minimum valve-open cycles before a moisture stop is honoured (1..MAX_ON).
- MAX_ON, 20, maximum valve-open cycles before timeout fault (≤255).
- SOAK_CYC, 8, valve-closed hold-off cycles after watering (≥1, ≤255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe; moisture/tank_level valid this cycle.
- moisture  input  W  soil moisture reading.
- tank_level  input  W  reservoir level reading.
- low_thr  input  W  start-watering threshold (moisture < low_thr).
- high_thr  input  W  stop-watering threshold (moisture >= high_thr).
- tank_min  input  W  minimum usable tank level (usable iff tank_level > tank_min).
- fault_clr  input  1  one-cycle pulse; clears FAULT.
- valve  output  1  valve open command, registered.
- alarm  output  1  timeout alarm, registered, high only in FAULT.
- tank_low  output  1  registered; last valid sample had tank_level <= tank_min.
- cfg_err  output  1  registered each cycle: low_thr >= high_thr.
- state  output  2  0=IDLE, 1=WATER, 2=SOAK, 3=FAULT.
- cycles_done  output  8  count of completed watering runs (WATER->SOAK), saturates at 255.

Behaviour:
- Reset (rst_n low, async): state=IDLE, valve=0, alarm=0, tank_low=0, cfg_err=0, cycles_done=0, on_cnt=0, soak_cnt=0. Reset mid-WATER closes the valve immediately (asynchronously).
- All comparisons are unsigned W-bit. Only inputs present on a sample_valid edge are acted on, except fault_clr and cfg_err.
- tank_low updates on every sample_valid edge in every state.
- IDLE:
  - On an edge with sample_valid=1 and moisture<low_thr and tank_level>tank_min and low_thr<high_thr: go to WATER, valve=1, on_cnt=1.
  - Otherwise remain in IDLE.
  - Latency: valve is visible high one edge after the triggering sample.
- WATER: valve=1; each edge without exit, on_cnt+=1. Exit priority, highest first:
  1. sample_valid and tank_level<=tank_min: go to SOAK, ignoring MIN_ON; cycles_done+=1.
  2. sample_valid and moisture>=high_thr and on_cnt>=MIN_ON: go to SOAK; cycles_done+=1.
  3. on_cnt==MAX_ON: go to FAULT, alarm=1, valve=0.
  - Valve is therefore high for at most MAX_ON consecutive cycles.
  - A moisture stop arriving before MIN_ON is dropped, not remembered.
- SOAK:
  - valve=0. soak_cnt is loaded to 1 on entry and incremented each edge.
  - At soak_cnt==SOAK_CYC, go to IDLE. Samples are ignored except for tank_low.
- FAULT:
  - valve=0, alarm=1.
  - On fault_clr=1, go to IDLE and set alarm=0.
  - fault_clr in any other state has no effect.
- cfg_err going high while in WATER does not abort the run; it only blocks new starts.
- cycles_done saturates at 255 and never wraps.
- state encoding 2'b11 is FAULT; no illegal states exist.

Test Plan:
- Reset, then thresholds low=5, high=10, tank_min=2; sample moisture=3, tank=8 -> valve=1 and state=1 one edge later.
- In WATER, sample moisture=12 at on_cnt=2 -> ignored, valve stays 1. Resample moisture=12 at on_cnt=5 -> state=SOAK, valve=0, cycles_done=1. After 8 edges -> state=IDLE.
- Start watering, never deliver a stop sample -> valve high exactly 20 cycles, then state=FAULT, alarm=1. Pulse fault_clr -> IDLE, alarm=0.
- In WATER at on_cnt=2, sample tank=2 with moisture=3 -> SOAK immediately, tank_low=1. In IDLE, sample moisture=1 with tank=2 -> no start.
- low_thr=10, high_thr=10 -> cfg_err=1. Sample moisture=0, tank=15 -> stays IDLE. Restore high_thr=11 -> cfg_err=0 and next sample starts watering.
- Drop rst_n asynchronously mid-WATER -> valve=0, state=IDLE, cycles_done=0 without a clock edge. 256 complete runs -> cycles_done stays 255.
